// File: rtl/data_mem_responder.sv
// Word-wide load/store responder: one outstanding request, byte-enable writes
// committed at acceptance, single-cycle response after LATENCY wait states.
// Optional MEM_ERR_EN: flag misaligned or out-of-range accesses with rsp_err.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int XLEN = 32;
    localparam int IW   = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, err_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            req_err;
    logic [XLEN-1:0] offset;
    logic [IW-1:0]   idx;
    logic            unused_bits;

    assign req_ready = rstn && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign offset    = req_addr - BASE_ADDR;
    assign idx       = offset[IW+1:2];

`ifdef MEM_ERR_EN
    // Upper offset bits set means the word index is past the array, including
    // addresses below BASE_ADDR, which wrap to huge offsets.
    assign req_err = (req_addr[1:0] != 2'b00) || (offset[XLEN-1:IW+2] != '0);
`else
    assign req_err = 1'b0;
`endif
    assign unused_bits = ^{offset[1:0], offset[XLEN-1:IW+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q  <= req_we;
                err_q <= req_err;
            end
        end
    end

    // Array and read capture carry no reset; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (accept) begin
            rdata_q <= req_err ? '0 : mem[idx];
            for (int i = 0; i < 4; i++) begin
                if (req_we && !req_err && req_be[i])
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: DUT index 0 runs LATENCY=2, index 1 LATENCY=0,
// both checked against a word-array reference model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn, req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata[2];
    logic [31:0] rsp_rdata[2];
    logic [3:0]  req_be   [2];

    logic [31:0] mdl[2][1024];
    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut_l2 (
        .clk(clk), .rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) dut_l0 (
        .clk(clk), .rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
`ifdef MEM_ERR_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
`else
        return 1'b0;
`endif
    endfunction

    // Reference access: expected response, then commit the write.
    task automatic model(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] erd, output logic eer);
        logic [31:0] w;
        int i;
        eer = is_err(a);
        w   = a >> 2;
        i   = int'(w % 32'd1024);
        erd = (we || eer) ? 32'h0 : mdl[d][i];
        if (we && !eer)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[d][i][8*b +: 8] = wd[8*b +: 8];
    endtask

    // Drives one request and reports what came back; no checking here.
    task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat, output logic rdy, output logic one);
        int n;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be; req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin @(negedge clk); lat++; end
        rd = rsp_rdata[d]; er = rsp_err[d]; rdy = req_ready[d];
        @(negedge clk);
        one = !rsp_valid[d] && req_ready[d];
    endtask

    task automatic test_reset();
        rstn = 2'b00; req_valid = 2'b00; req_we = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready_low[%0d]: got %b want 0", d, req_ready[d]); end
            checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); end
            checks++; if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); end
            checks++; if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", d, rsp_err[d]); end
        end
        rstn = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready_high[%0d]: got %b want 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd; logic er, eer, rdy, one; int lat;
        logic        we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] wd [4] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'h0};
        logic [3:0]  be [4] = '{4'hF, 4'h0, 4'b0101, 4'h0};
        logic [31:0] fix[4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDE22BE44};
        for (int k = 0; k < 4; k++) begin
            model(0, we[k], 32'h10, wd[k], be[k], erd, eer);
            xact(0, we[k], 32'h10, wd[k], be[k], rd, er, lat, rdy, one);
            checks++; if (lat !== 2) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want 2", k, lat); end
            checks++; if (rd !== fix[k] || rd !== erd) begin errors++; $display("FAIL basic_rdata[%0d]: got %h want %h", k, rd, fix[k]); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_err[%0d]: got %b want 0", k, er); end
            checks++; if (one !== 1'b1) begin errors++; $display("FAIL basic_one_cycle[%0d]: got %b want 1", k, one); end
        end
    endtask

    task automatic test_be_zero();
        logic [31:0] rd, erd; logic er, eer, rdy, one; int lat;
        model(0, 1'b1, 32'h10, 32'h55AA55AA, 4'h0, erd, eer);
        xact(0, 1'b1, 32'h10, 32'h55AA55AA, 4'h0, rd, er, lat, rdy, one);
        checks++; if (lat !== 2) begin errors++; $display("FAIL be0_lat: got %0d want 2", lat); end
        model(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy, one);
        checks++; if (rd !== erd) begin errors++; $display("FAIL be0_unchanged: got %h want %h", rd, erd); end
    endtask

    task automatic test_lat0();
        logic [31:0] rd, erd, wv; logic er, eer, rdy, one; int lat;
        @(negedge clk); rstn[1] = 1'b0;
        @(negedge clk); rstn[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wv = $urandom;
            model(1, (k == 0), 32'h40, wv, 4'hF, erd, eer);
            xact(1, (k == 0), 32'h40, wv, 4'hF, rd, er, lat, rdy, one);
            checks++; if (lat !== 0) begin errors++; $display("FAIL lat0_lat[%0d]: got %0d want 0", k, lat); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lat0_ready_in_resp[%0d]: got %b want 0", k, rdy); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL lat0_rdata[%0d]: got %h want %h", k, rd, erd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad[8], wd[8], erd;
        logic [31:0] exp_q[$];
        logic        eer;
        int          acc[$];
        int          idx = 0, nrsp = 0;
        bit          take;
        for (int k = 0; k < 8; k++) begin
            ad[k] = 32'h100 + 32'((k / 2) * 4); wd[k] = $urandom;
        end
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_addr[0] = ad[0]; req_wdata[0] = wd[0]; req_be[0] = 4'hF; req_valid[0] = 1'b1;
        for (int cyc = 0; cyc < 100 && (idx < 8 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                nrsp++;
                checks++; if (exp_q.size() == 0 || rsp_rdata[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_rdata: got %h want %h", rsp_rdata[0], (exp_q.size() > 0) ? exp_q[0] : 32'h0); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 0", req_ready[0]); end
            end
            take = req_valid[0] && req_ready[0];
            if (take) begin
                model(0, req_we[0], req_addr[0], req_wdata[0], 4'hF, erd, eer);
                exp_q.push_back(erd);
                acc.push_back(cyc);
            end
            @(posedge clk); #1;
            if (take) begin
                idx++;
                if (idx < 8) begin
                    req_we[0] = (idx % 2 == 0); req_addr[0] = ad[idx]; req_wdata[0] = wd[idx];
                end else req_valid[0] = 1'b0;
            end
        end
        req_valid[0] = 1'b0;
        checks++; if (nrsp !== 8 || acc.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d rsp %0d acc want 8", nrsp, acc.size()); end
        for (int k = 1; k < acc.size(); k++) begin
            checks++; if (acc[k] - acc[k-1] !== 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", k, acc[k] - acc[k-1]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer, rdy, one, pulse; int lat, n;
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF; req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        model(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, erd, eer);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rstn[0] = 1'b0;
        pulse = 1'b0;
        #1;
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL rmid_ready_low: got %b want 0", req_ready[0]); end
        repeat (2) begin @(negedge clk); if (rsp_valid[0]) pulse = 1'b1; end
        rstn[0] = 1'b1;
        repeat (6) begin @(negedge clk); if (rsp_valid[0] || !req_ready[0]) pulse = 1'b1; end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got %b want 0", pulse); end
        model(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rdy, one);
        checks++; if (rd !== 32'hCAFEF00D || rd !== erd) begin errors++; $display("FAIL rmid_rdata: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wv; logic er, eer, rdy, one, we; logic [3:0] be; int lat;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                wv = $urandom;
                model(d, 1'b1, 32'(w * 4), wv, 4'hF, erd, eer);
                xact(d, 1'b1, 32'(w * 4), wv, 4'hF, rd, er, lat, rdy, one);
            end
            for (int k = 0; k < 30; k++) begin
                a  = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) * 4096);
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                we = $urandom_range(0, 1) == 1; wv = $urandom; be = 4'($urandom);
                model(d, we, a, wv, be, erd, eer);
                xact(d, we, a, wv, be, rd, er, lat, rdy, one);
                checks++; if (rd !== erd || er !== eer || lat !== lat_of(d)) begin
                    errors++; $display("FAIL rand[%0d.%0d] a=%h we=%b: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                                       d, k, a, we, rd, er, lat, erd, eer, lat_of(d));
                end
            end
        end
    endtask

    task automatic test_err();
        logic [31:0] rd, erd, w0; logic er, eer, rdy, one; int lat;
        w0 = mdl[0][0];
`ifdef MEM_ERR_EN
        model(0, 1'b1, 32'h1002, 32'h12345678, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h1002, 32'h12345678, 4'hF, rd, er, lat, rdy, one);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL err_write: got err=%b rd=%h lat=%0d want 1 0 2", er, rd, lat); end
        model(0, 1'b0, 32'h1000, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, rdy, one);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_read: got err=%b rd=%h want 1 0", er, rd); end
        model(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rdy, one);
        checks++; if (rd !== w0 || er !== 1'b0) begin errors++; $display("FAIL err_array_unchanged: got %h want %h", rd, w0); end
`else
        model(0, 1'b0, 32'h1000, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, rdy, one);
        checks++; if (rd !== w0 || rd !== erd || er !== 1'b0) begin errors++; $display("FAIL wrap_read: got rd=%h err=%b want rd=%h err=0", rd, er, w0); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_be_zero();
        test_lat0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
